// File: rtl/sub_pkg.sv
// ---------------------------------------------------------------------------
// sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default operand/result width
//   cntWidth()    : bit counter width for a given operand width
//   CNT_W         : counter width for the default operand width
// ---------------------------------------------------------------------------
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 16;

  // One extra bit so the counter can hold WIDTH itself after the last bit.
  function automatic int cntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cntWidth(WIDTH_DEFAULT);

endpackage

// File: rtl/fsub1.sv
// ---------------------------------------------------------------------------
// fsub1
// Combinational 1-bit full subtractor: computes a - b - bin.
//   a   : minuend bit
//   b   : subtrahend bit
//   bin : borrow in
//   d   : difference bit
//   bo  : borrow out
// ---------------------------------------------------------------------------
module fsub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  // A borrow leaves this bit when b exceeds a outright, or when the bits are
  // equal and a borrow is already coming in from below.
  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub16.sv
// ---------------------------------------------------------------------------
// serial_sub16
// Bit-serial subtractor computing A - B one bit per clock, LSB first.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   start : request, sampled only while ready is high
//   A, B  : minuend / subtrahend, captured on an accepted start
//   ready : high in IDLE
//   busy  : high in RUN
//   done  : one-cycle pulse when the result is valid
//   diff  : A - B modulo 2^WIDTH
//   c     : borrow chain, c[0] = 0, c[i+1] = borrow out of bit i
//   bout  : final borrow (A < B unsigned)
//   ovf   : signed overflow of the subtraction
// ---------------------------------------------------------------------------
module serial_sub16
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH:0]   c,
  output logic             bout,
  output logic             ovf
);

  localparam int CntW = cntWidth(WIDTH);
  localparam int IdxW = $clog2(WIDTH);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  aSh_q, aSh_d;
  logic [WIDTH-1:0]  bSh_q, bSh_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [WIDTH:0]    c_q, c_d;
  logic              borrow_q, borrow_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic              bitD;
  logic              bitBo;
  logic [IdxW-1:0]   bitIdx;
  logic [CntW-1:0]   cIdx;
  logic              lastBit;

  assign bitIdx  = cnt_q[IdxW-1:0];
  assign cIdx    = cnt_q + CntW'(1);
  assign lastBit = (cnt_q == CntW'(WIDTH - 1));

  // The single full subtractor always works on the LSB of the operand shift
  // registers; the registers shift right once per processed bit.
  fsub1 uBit (
    .a   (aSh_q[0]),
    .b   (bSh_q[0]),
    .bin (borrow_q),
    .d   (bitD),
    .bo  (bitBo)
  );

  // Next-state and datapath update. Result registers keep their value through
  // DONE and IDLE, and are only cleared when a new start is accepted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    diff_d   = diff_q;
    c_d      = c_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          aSh_d    = A;
          bSh_d    = B;
          diff_d   = '0;
          c_d      = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          bout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end

      RUN: begin
        diff_d[bitIdx] = bitD;
        c_d[cIdx]      = bitBo;
        borrow_d       = bitBo;
        cnt_d          = cnt_q + CntW'(1);
        aSh_d          = aSh_q >> 1;
        bSh_d          = bSh_q >> 1;
        // On the MSB the shift-register LSBs are the operand sign bits, so
        // overflow is judged from them and the freshly computed sign of diff.
        if (lastBit) begin
          state_d = DONE;
          bout_d  = bitBo;
          ovf_d   = (aSh_q[0] ^ bSh_q[0]) & (bitD ^ aSh_q[0]);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial result at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      aSh_q    <= '0;
      bSh_q    <= '0;
      diff_q   <= '0;
      c_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      diff_q   <= diff_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign c     = c_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;

endmodule
